mii_rx_deframer: RTL and testbench

- Receive-side MII framing stage. Sits between the PHY MII RX pins and the RX frame buffer.
- Samples 4-bit nibbles on enet_rx_clk, strips preamble/SFD and pairs nibbles into bytes (low nibble first).
- Emits a byte stream with per-frame start and completion strobes.
- Checks FCS (CRC-32), alignment, runt/oversize and PHY error, then reports one status word per frame.

---
 rtl/mii_net_pkg.sv | 29 ++
 rtl/crc32_d8.sv | 27 ++
 rtl/mii_rx_deframer.sv | 210 +++++++++++++++++++++
 tb/tb_mii_rx_deframer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mii_net_pkg.sv
// Shared definitions for the MII receive/transmit framing logic.
//   rx_state_t     - receive deframer FSM states
//   CRC32_*        - reflected Ethernet CRC-32 constants
//   *_NIBBLE       - preamble / start-of-frame-delimiter nibble values
//   ERR_*          - bit positions inside the per-frame error word
package mii_net_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_DATA     = 2'd2,
        S_DROP     = 2'd3
    } rx_state_t;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    // Register value left behind after running a frame together with its own FCS.
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

    localparam logic [3:0] PRE_NIBBLE = 4'h5;
    localparam logic [3:0] SFD_NIBBLE = 4'hD;

    localparam int ERR_CRC      = 0;
    localparam int ERR_ALIGN    = 1;
    localparam int ERR_RUNT     = 2;
    localparam int ERR_OVERSIZE = 3;
    localparam int ERR_RX_ER    = 4;

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
// Shared between the receive checker and the transmit FCS generator.
//   crc_in  [31:0] - current CRC register
//   data    [7:0]  - byte to absorb, consumed LSB first
//   crc_out [31:0] - CRC register after absorbing data
module crc32_d8
    import mii_net_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC32_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, pairs nibbles into bytes
// (low nibble first), checks the frame and reports one status word per frame.
//   enet_rx_clk    - PHY receive clock, sole clock
//   i_reset        - synchronous active-high reset
//   enet_rx_dv/er  - MII data valid / receive error
//   enet_rx_data   - MII receive nibble
//   o_data/o_valid - received byte stream, FCS included
//   o_sof          - marks the first byte of a frame
//   o_done         - one-cycle end-of-frame strobe qualifying o_len/o_good/o_err
//   o_err          - {rx_er, oversize, runt, align, crc}
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | line quiet, waiting for the first preamble nibble
// PREAMBLE | counting 0x5 nibbles, waiting for SFD
// DATA     | assembling bytes, updating CRC and frame length
// DROP     | malformed start, ignore everything until dv falls
module mii_rx_deframer
    import mii_net_pkg::*;
#(
    parameter int MIN_PRE = 8,
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64
) (
    input  logic        enet_rx_clk,
    input  logic        i_reset,
    input  logic        enet_rx_dv,
    input  logic        enet_rx_er,
    input  logic [3:0]  enet_rx_data,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_sof,
    output logic        o_done,
    output logic [10:0] o_len,
    output logic        o_good,
    output logic [4:0]  o_err
);

    localparam logic [3:0]  MIN_PRE_C = 4'(MIN_PRE);
    localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);
    localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);

    logic        r_dv;
    logic        r_er;
    logic [3:0]  r_nib;

    rx_state_t   state;
    rx_state_t   state_nxt;
    logic        start_frame;
    logic        end_frame;

    logic [3:0]  pre_cnt;
    logic [10:0] byte_cnt;
    logic        nib_phase;
    logic [3:0]  low_nib;
    logic [31:0] crc;
    logic [31:0] crc_nxt;
    logic        flag_rx_er;
    logic        flag_oversize;
    logic        byte_done;
    logic [7:0]  cur_byte;
    logic [4:0]  frame_err;

    always_ff @(posedge enet_rx_clk) begin
        if (i_reset) begin
            r_dv  <= 1'b0;
            r_er  <= 1'b0;
            r_nib <= 4'h0;
        end else begin
            r_dv  <= enet_rx_dv;
            r_er  <= enet_rx_er;
            r_nib <= enet_rx_data;
        end
    end

    always_ff @(posedge enet_rx_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        case (state)
            S_IDLE: begin
                if (r_dv) begin
                    state_nxt = (r_nib == PRE_NIBBLE) ? S_PREAMBLE : S_DROP;
                end
            end
            S_PREAMBLE: begin
                if (!r_dv) begin
                    state_nxt = S_IDLE;
                end else if (r_nib == PRE_NIBBLE) begin
                    state_nxt = S_PREAMBLE;
                end else if (r_nib == SFD_NIBBLE && pre_cnt >= MIN_PRE_C) begin
                    state_nxt   = S_DATA;
                    start_frame = 1'b1;
                end else begin
                    state_nxt = S_DROP;
                end
            end
            S_DATA: begin
                if (!r_dv) begin
                    state_nxt = S_IDLE;
                    end_frame = 1'b1;
                end
            end
            S_DROP: begin
                if (!r_dv) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign cur_byte  = {r_nib, low_nib};
    assign byte_done = (state == S_DATA) && r_dv && nib_phase;

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (cur_byte),
        .crc_out (crc_nxt)
    );

    // Evaluated in the dv-low cycle, when count and CRC already include the last byte.
    always_comb begin
        frame_err               = 5'b0;
        frame_err[ERR_CRC]      = (crc != CRC32_RESIDUE);
        frame_err[ERR_ALIGN]    = nib_phase;
        frame_err[ERR_RUNT]     = (byte_cnt < MIN_LEN_C);
        frame_err[ERR_OVERSIZE] = flag_oversize;
        frame_err[ERR_RX_ER]    = flag_rx_er;
    end

    always_ff @(posedge enet_rx_clk) begin
        if (i_reset) begin
            pre_cnt       <= 4'd0;
            byte_cnt      <= 11'd0;
            nib_phase     <= 1'b0;
            low_nib       <= 4'h0;
            crc           <= 32'h0;
            flag_rx_er    <= 1'b0;
            flag_oversize <= 1'b0;
            o_data        <= 8'h0;
            o_valid       <= 1'b0;
            o_sof         <= 1'b0;
            o_done        <= 1'b0;
            o_len         <= 11'd0;
            o_good        <= 1'b0;
            o_err         <= 5'b0;
        end else begin
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_done  <= 1'b0;

            if (state == S_IDLE && r_dv && r_nib == PRE_NIBBLE) begin
                pre_cnt <= 4'd1;
            end else if (state == S_PREAMBLE && r_dv && r_nib == PRE_NIBBLE &&
                         pre_cnt != 4'hF) begin
                pre_cnt <= pre_cnt + 4'd1;
            end

            if (start_frame) begin
                byte_cnt      <= 11'd0;
                nib_phase     <= 1'b0;
                crc           <= CRC32_INIT;
                flag_rx_er    <= 1'b0;
                flag_oversize <= 1'b0;
            end

            if (state == S_DATA && r_dv) begin
                nib_phase <= ~nib_phase;
                if (r_er) begin
                    flag_rx_er <= 1'b1;
                end
                if (!nib_phase) begin
                    low_nib <= r_nib;
                end
            end

            // Bytes past MAX_LEN still feed the CRC and length, only the stream stops.
            if (byte_done) begin
                crc <= crc_nxt;
                if (byte_cnt != 11'h7FF) begin
                    byte_cnt <= byte_cnt + 11'd1;
                end
                if (byte_cnt < MAX_LEN_C) begin
                    o_valid <= 1'b1;
                    o_data  <= cur_byte;
                    o_sof   <= (byte_cnt == 11'd0);
                end else begin
                    flag_oversize <= 1'b1;
                end
            end

            if (end_frame) begin
                o_done <= 1'b1;
                o_len  <= byte_cnt;
                o_err  <= frame_err;
                o_good <= (frame_err == 5'b0);
            end
        end
    end

endmodule

// File: tb/tb_mii_rx_deframer.sv
module tb_mii_rx_deframer;

    logic        enet_rx_clk = 1'b0;
    logic        i_reset;
    logic        enet_rx_dv;
    logic        enet_rx_er;
    logic [3:0]  enet_rx_data;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_sof;
    logic        o_done;
    logic [10:0] o_len;
    logic        o_good;
    logic [4:0]  o_err;

    always #20 enet_rx_clk = ~enet_rx_clk;

    mii_rx_deframer dut (
        .enet_rx_clk  (enet_rx_clk),
        .i_reset      (i_reset),
        .enet_rx_dv   (enet_rx_dv),
        .enet_rx_er   (enet_rx_er),
        .enet_rx_data (enet_rx_data),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_sof        (o_sof),
        .o_done       (o_done),
        .o_len        (o_len),
        .o_good       (o_good),
        .o_err        (o_err)
    );

    typedef struct {
        int         npre;
        int         bad_pre;
        int         nbytes;
        int         flip;
        bit         extra;
        int         er_at;
        int         exp_nvalid;
        int         exp_done;
        int         exp_len;
        logic [4:0] exp_err;
        int         exp_good;
        int         exp_gap;
    } vec_t;

    vec_t vecs [13];

    int checks = 0;
    int errors = 0;

    logic [7:0] fb [0:2047];
    logic [7:0] exp_q [$];

    int cyc = 0;
    int nvalid, nsof, sof_bad, data_err, extra_bytes, ndone, overlap, last_valid_cyc, d_gap;
    logic [10:0] d_len;
    logic [4:0]  d_err;
    logic        d_good;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c;
        for (int i = 0; i < 8; i++) begin
            if (x[0] ^ b[i]) x = (x >> 1) ^ 32'hEDB88320;
            else             x = x >> 1;
        end
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        nvalid = 0; nsof = 0; sof_bad = 0; data_err = 0; extra_bytes = 0;
        ndone = 0; overlap = 0; last_valid_cyc = 0; d_gap = -1;
        d_len = '0; d_err = '0; d_good = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge enet_rx_clk);
            cyc++;
            if (o_valid) begin
                nvalid++;
                if (exp_q.size() == 0) begin
                    extra_bytes++;
                end else begin
                    e = exp_q.pop_front();
                    if (o_data !== e) data_err++;
                end
                if (o_sof) begin
                    nsof++;
                    if (nvalid != 1 && nsof > 1 && last_valid_cyc != 0 && cyc - last_valid_cyc < 4) sof_bad++;
                end
                last_valid_cyc = cyc;
            end else if (o_sof) begin
                sof_bad++;
            end
            if (o_done) begin
                ndone++;
                d_len  = o_len;
                d_err  = o_err;
                d_good = o_good;
                d_gap  = cyc - last_valid_cyc;
            end
            if (o_valid && o_done) overlap++;
        end
    end

    task automatic drive(input logic dv, input logic er, input logic [3:0] nib);
        @(posedge enet_rx_clk); #1;
        enet_rx_dv   = dv;
        enet_rx_er   = er;
        enet_rx_data = nib;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0);
    endtask

    task automatic send_frame(input int npre, input int bad_pre, input int nbytes, input int flip,
                              input bit extra_nib, input int er_at, input int rst_at, input int exp_n);
        logic [31:0] c;
        logic [3:0]  nib;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < nbytes - 4; i++) begin
            fb[i] = 8'((i * 37 + 11) % 256);
            c = crc_upd(c, fb[i]);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) fb[nbytes - 4 + i] = c[8*i +: 8];
        if (flip >= 0) fb[flip / 8][flip % 8] = ~fb[flip / 8][flip % 8];
        for (int i = 0; i < exp_n; i++) exp_q.push_back(fb[i]);

        for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, (i == bad_pre) ? 4'h4 : 4'h5);
        drive(1'b1, 1'b0, 4'hD);
        for (int i = 0; i < 2 * nbytes; i++) begin
            nib = i[0] ? fb[i / 2][7:4] : fb[i / 2][3:0];
            @(posedge enet_rx_clk); #1;
            if (rst_at >= 0 && i == rst_at + 1)
                chk("rst_outputs_zero", 32'({o_data, o_valid, o_sof, o_done, o_len, o_good, o_err}), 0);
            i_reset      = (i == rst_at);
            enet_rx_dv   = 1'b1;
            enet_rx_er   = (i == er_at);
            enet_rx_data = nib;
        end
        if (extra_nib) drive(1'b1, 1'b0, 4'h3);
        drive(1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        //           npre bad  nbytes flip  ext er   nval done len  err       good gap
        vecs[0]  = '{15, -1,   64,   -1,   0, -1,   64, 1,   64, 5'b00000, 1, 1};
        vecs[1]  = '{15, -1,   64,   83,   0, -1,   64, 1,   64, 5'b00001, 0, 1};
        vecs[2]  = '{15, -1,   64,   -1,   1, -1,   64, 1,   64, 5'b00010, 0, 2};
        vecs[3]  = '{15, -1,   20,   -1,   0, -1,   20, 1,   20, 5'b00100, 0, 1};
        vecs[4]  = '{15, -1, 1600,   -1,   0, -1, 1518, 1, 1600, 5'b01000, 0, 0};
        vecs[5]  = '{15, -1,   64,   -1,   0, 30,   64, 1,   64, 5'b10000, 0, 1};
        vecs[6]  = '{ 4, -1,   64,   -1,   0, -1,    0, 0,    0, 5'b00000, 0, 0};
        vecs[7]  = '{15,  6,   64,   -1,   0, -1,    0, 0,    0, 5'b00000, 0, 0};
        vecs[8]  = '{ 8, -1,   64,   -1,   0, -1,   64, 1,   64, 5'b00000, 1, 1};
        vecs[9]  = '{ 7, -1,   64,   -1,   0, -1,    0, 0,    0, 5'b00000, 0, 0};
        vecs[10] = '{15, -1,   63,   -1,   0, -1,   63, 1,   63, 5'b00100, 0, 1};
        vecs[11] = '{15, -1, 1518,   -1,   0, -1, 1518, 1, 1518, 5'b00000, 1, 1};
        vecs[12] = '{15, -1,   64,   -1,   1, -1,   64, 1,   64, 5'b00010, 0, 2};

        i_reset = 1'b1;
        enet_rx_dv = 1'b0;
        enet_rx_er = 1'b0;
        enet_rx_data = 4'h0;
        clear_mon();
        repeat (3) @(posedge enet_rx_clk);
        #1;
        chk("reset_outputs", 32'({o_data, o_valid, o_sof, o_done, o_len, o_good, o_err}), 0);
        i_reset = 1'b0;
        idle(4);

        for (int k = 0; k < 13; k++) begin
            clear_mon();
            send_frame(vecs[k].npre, vecs[k].bad_pre, vecs[k].nbytes, vecs[k].flip,
                       vecs[k].extra, vecs[k].er_at, -1, vecs[k].exp_nvalid);
            idle(8);
            chk($sformatf("v%0d_nvalid", k), nvalid, vecs[k].exp_nvalid);
            chk($sformatf("v%0d_data", k), data_err + extra_bytes, 0);
            chk($sformatf("v%0d_sof", k), nsof, (vecs[k].exp_nvalid > 0) ? 1 : 0);
            chk($sformatf("v%0d_sof_place", k), sof_bad, 0);
            chk($sformatf("v%0d_ndone", k), ndone, vecs[k].exp_done);
            chk($sformatf("v%0d_overlap", k), overlap, 0);
            if (vecs[k].exp_done != 0) begin
                chk($sformatf("v%0d_len", k), 32'(d_len), vecs[k].exp_len);
                chk($sformatf("v%0d_err", k), 32'(d_err), 32'(vecs[k].exp_err));
                chk($sformatf("v%0d_good", k), 32'(d_good), vecs[k].exp_good);
            end
            if (vecs[k].exp_gap != 0)
                chk($sformatf("v%0d_done_gap", k), d_gap, vecs[k].exp_gap);
        end

        // Short preamble, one idle cycle, then a valid frame.
        clear_mon();
        send_frame(4, -1, 64, -1, 1'b0, -1, -1, 0);
        send_frame(15, -1, 64, -1, 1'b0, -1, -1, 64);
        idle(8);
        chk("b2b_drop_ndone", ndone, 1);
        chk("b2b_drop_good", 32'(d_good), 1);
        chk("b2b_drop_nvalid", nvalid, 64);
        chk("b2b_drop_data", data_err + extra_bytes, 0);

        // Two good frames separated by a single dv-low cycle.
        clear_mon();
        send_frame(15, -1, 64, -1, 1'b0, -1, -1, 64);
        send_frame(15, -1, 70, -1, 1'b0, -1, -1, 70);
        idle(8);
        chk("b2b_ndone", ndone, 2);
        chk("b2b_nvalid", nvalid, 134);
        chk("b2b_len", 32'(d_len), 70);
        chk("b2b_good", 32'(d_good), 1);
        chk("b2b_overlap", overlap, 0);
        chk("b2b_data", data_err + extra_bytes, 0);

        // One-cycle reset during data nibble 40: bytes 0..18 escape, then nothing.
        clear_mon();
        send_frame(15, -1, 64, -1, 1'b0, -1, 40, 19);
        idle(8);
        chk("rst_nvalid", nvalid, 19);
        chk("rst_ndone", ndone, 0);
        chk("rst_data", data_err + extra_bytes, 0);
        clear_mon();
        send_frame(15, -1, 64, -1, 1'b0, -1, -1, 64);
        idle(8);
        chk("post_rst_ndone", ndone, 1);
        chk("post_rst_good", 32'(d_good), 1);
        chk("post_rst_len", 32'(d_len), 64);
        chk("post_rst_data", data_err + extra_bytes, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
